// File: rtl/ysyx_22041211_idu_stage.sv
// rtl/ysyx_22041211_idu_stage.sv - queued, registered RV32I decode stage between IFU and EXU
// Optional macro YSYX_22041211_RV32E_EN: register indices >= 16 decode as illegal.
module ysyx_22041211_idu_stage #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] PC_RESET = 32'h8000_0000
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        flush,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_pc,
   input  logic [31:0] in_inst,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_imm,
   output logic [4:0]  out_rs1,
   output logic [4:0]  out_rs2,
   output logic [4:0]  out_rd,
   output logic        out_wd,
   output logic [3:0]  out_aluop,
   output logic [3:0]  out_alusel,
   output logic [2:0]  out_branch_type,
   output logic [1:0]  out_store_type,
   output logic [2:0]  out_load_type,
   output logic        out_jmp,
   output logic        out_jalr,
   output logic [1:0]  out_csr_flag,
   output logic [11:0] out_csr_addr,
   output logic [1:0]  out_sys,
   output logic        out_illegal
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

   localparam logic [3:0] ALU_NONE = 4'd0, ALU_ADD = 4'd1, ALU_SUB = 4'd2, ALU_SLL = 4'd3,
                          ALU_SLT = 4'd4, ALU_SLTU = 4'd5, ALU_XOR = 4'd6, ALU_SRL = 4'd7,
                          ALU_SRA = 4'd8, ALU_OR = 4'd9, ALU_AND = 4'd10;
   // alusel = {operand1 select, operand2 select}: op1 1=rs1 2=pc 3=zero, op2 1=rs2 2=imm 3=four
   localparam logic [3:0] SEL_NONE = 4'b0000, SEL_R1 = 4'b0100, SEL_RR = 4'b0101,
                          SEL_RI = 4'b0110, SEL_PI = 4'b1010, SEL_P4 = 4'b1011, SEL_ZI = 4'b1110;
   localparam logic [2:0] BR_NONE = 3'd0, BR_BEQ = 3'd1, BR_BNE = 3'd2, BR_BLT = 3'd3,
                          BR_BGE = 3'd4, BR_BLTU = 3'd5, BR_BGEU = 3'd6;
   localparam logic [1:0] ST_NONE = 2'd0, ST_SB = 2'd1, ST_SH = 2'd2, ST_SW = 2'd3;
   localparam logic [2:0] LD_NONE = 3'd0, LD_LB = 3'd1, LD_LH = 3'd2, LD_LW = 3'd3,
                          LD_LBU = 3'd4, LD_LHU = 3'd5;
   localparam logic [1:0] CSR_NONE = 2'd0, CSR_RW = 2'd1, CSR_RS = 2'd2;
   localparam logic [1:0] SYS_NONE = 2'd0, SYS_ECALL = 2'd1, SYS_EBREAK = 2'd2, SYS_MRET = 2'd3;

   localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LOAD = 7'b0000011,
                          OP_STORE = 7'b0100011, OP_BRANCH = 7'b1100011, OP_JAL = 7'b1101111,
                          OP_JALR = 7'b1100111, OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111,
                          OP_SYS = 7'b1110011;

   logic [31:0]   q_pc   [DEPTH];
   logic [31:0]   q_inst [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic [AW:0]   count;
   logic          push, pop;

   assign in_ready = (count != CNT_FULL);
   assign push     = in_valid & in_ready;
   assign pop      = (count != '0) & (~out_valid | out_ready);

   always_ff @(posedge clock) begin
      if (push) begin
         q_pc[wptr]   <= in_pc;
         q_inst[wptr] <= in_inst;
      end
   end

   always_ff @(posedge clock) begin
      if (reset || flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push) wptr <= wptr + 1'b1;
         if (pop)  rptr <= rptr + 1'b1;
         if (push && !pop)      count <= count + 1'b1;
         else if (!push && pop) count <= count - 1'b1;
      end
   end

   logic [31:0] inst;
   logic [6:0]  opcode, f7;
   logic [2:0]  f3;
   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;

   assign inst   = q_inst[rptr];
   assign opcode = inst[6:0];
   assign f3     = inst[14:12];
   assign f7     = inst[31:25];
   assign imm_i  = {{20{inst[31]}}, inst[31:20]};
   assign imm_s  = {{20{inst[31]}}, inst[31:25], inst[11:7]};
   assign imm_b  = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
   assign imm_u  = {inst[31:12], 12'b0};
   assign imm_j  = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};

   function automatic logic [3:0] alu_of(input logic [2:0] fn3, input logic alt);
      case (fn3)
         3'd0:    return alt ? ALU_SUB : ALU_ADD;
         3'd1:    return ALU_SLL;
         3'd2:    return ALU_SLT;
         3'd3:    return ALU_SLTU;
         3'd4:    return ALU_XOR;
         3'd5:    return alt ? ALU_SRA : ALU_SRL;
         3'd6:    return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   logic        d_legal, d_wd, d_jmp, d_jalr, dec_ok, rv32e_bad;
   logic [31:0] d_imm;
   logic [3:0]  d_aluop, d_alusel;
   logic [2:0]  d_br, d_ld;
   logic [1:0]  d_st, d_csr, d_sys;

   always_comb begin
      d_legal = 1'b0; d_wd = 1'b0; d_jmp = 1'b0; d_jalr = 1'b0; d_imm = '0;
      d_aluop = ALU_NONE; d_alusel = SEL_NONE; d_br = BR_NONE; d_st = ST_NONE;
      d_ld = LD_NONE; d_csr = CSR_NONE; d_sys = SYS_NONE;
      case (opcode)
         OP_R: begin
            d_wd = 1'b1; d_alusel = SEL_RR; d_aluop = alu_of(f3, f7[5]);
            d_legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
         end
         OP_I: begin
            // imm[11:5] doubles as funct7 only for shifts; addi must ignore it
            d_wd = 1'b1; d_alusel = SEL_RI; d_imm = imm_i;
            d_aluop = (f3 == 3'd0) ? ALU_ADD : alu_of(f3, f7[5]);
            if (f3 == 3'd1)      d_legal = (f7 == 7'h00);
            else if (f3 == 3'd5) d_legal = (f7 == 7'h00) || (f7 == 7'h20);
            else                 d_legal = 1'b1;
         end
         OP_LOAD: begin
            d_wd = 1'b1; d_alusel = SEL_RI; d_aluop = ALU_ADD; d_imm = imm_i;
            case (f3)
               3'd0: d_ld = LD_LB;  3'd1: d_ld = LD_LH;  3'd2: d_ld = LD_LW;
               3'd4: d_ld = LD_LBU; 3'd5: d_ld = LD_LHU; default: d_ld = LD_NONE;
            endcase
            d_legal = (d_ld != LD_NONE);
         end
         OP_STORE: begin
            d_alusel = SEL_RI; d_aluop = ALU_ADD; d_imm = imm_s;
            case (f3)
               3'd0: d_st = ST_SB; 3'd1: d_st = ST_SH; 3'd2: d_st = ST_SW; default: d_st = ST_NONE;
            endcase
            d_legal = (d_st != ST_NONE);
         end
         OP_BRANCH: begin
            d_alusel = SEL_RR; d_imm = imm_b;
            case (f3)
               3'd0: d_br = BR_BEQ;  3'd1: d_br = BR_BNE;  3'd4: d_br = BR_BLT;
               3'd5: d_br = BR_BGE;  3'd6: d_br = BR_BLTU; 3'd7: d_br = BR_BGEU;
               default: d_br = BR_NONE;
            endcase
            d_legal = (d_br != BR_NONE);
         end
         OP_JAL: begin
            d_legal = 1'b1; d_wd = 1'b1; d_jmp = 1'b1;
            d_alusel = SEL_P4; d_aluop = ALU_ADD; d_imm = imm_j;
         end
         OP_JALR: begin
            d_legal = (f3 == 3'd0); d_wd = 1'b1; d_jmp = 1'b1; d_jalr = 1'b1;
            d_alusel = SEL_P4; d_aluop = ALU_ADD; d_imm = imm_i;
         end
         OP_LUI: begin
            d_legal = 1'b1; d_wd = 1'b1; d_alusel = SEL_ZI; d_aluop = ALU_ADD; d_imm = imm_u;
         end
         OP_AUIPC: begin
            d_legal = 1'b1; d_wd = 1'b1; d_alusel = SEL_PI; d_aluop = ALU_ADD; d_imm = imm_u;
         end
         OP_SYS: begin
            if (f3 == 3'd1 || f3 == 3'd2) begin
               d_legal = 1'b1; d_wd = 1'b1; d_alusel = SEL_R1;
               d_csr = (f3 == 3'd1) ? CSR_RW : CSR_RS;
            end else if (inst == 32'h0000_0073) begin
               d_legal = 1'b1; d_sys = SYS_ECALL;
            end else if (inst == 32'h0010_0073) begin
               d_legal = 1'b1; d_sys = SYS_EBREAK;
            end else if (inst == 32'h3020_0073) begin
               d_legal = 1'b1; d_sys = SYS_MRET;
            end
         end
         default: d_legal = 1'b0;
      endcase
   end

`ifdef YSYX_22041211_RV32E_EN
   logic use_rs1, use_rs2;
   always_comb begin
      use_rs1 = (opcode == OP_R) || (opcode == OP_I) || (opcode == OP_LOAD) ||
                (opcode == OP_STORE) || (opcode == OP_BRANCH) || (opcode == OP_JALR) ||
                (opcode == OP_SYS && (f3 == 3'd1 || f3 == 3'd2));
      use_rs2 = (opcode == OP_R) || (opcode == OP_STORE) || (opcode == OP_BRANCH);
   end
   assign rv32e_bad = (d_wd & inst[11]) | (use_rs1 & inst[19]) | (use_rs2 & inst[24]);
`else
   assign rv32e_bad = 1'b0;
`endif

   assign dec_ok = d_legal & ~rv32e_bad;

   always_ff @(posedge clock) begin
      if (reset) begin
         out_valid <= 1'b0; out_pc <= PC_RESET; out_imm <= '0;
         out_rs1 <= '0; out_rs2 <= '0; out_rd <= '0; out_wd <= 1'b0;
         out_aluop <= '0; out_alusel <= '0; out_branch_type <= '0;
         out_store_type <= '0; out_load_type <= '0; out_jmp <= 1'b0; out_jalr <= 1'b0;
         out_csr_flag <= '0; out_csr_addr <= '0; out_sys <= '0; out_illegal <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
         out_pc    <= PC_RESET;
      end else if (pop) begin
         out_valid       <= 1'b1;
         out_pc          <= q_pc[rptr];
         out_rs1         <= inst[19:15];
         out_rs2         <= inst[24:20];
         out_csr_addr    <= inst[31:20];
         out_illegal     <= ~dec_ok;
         out_imm         <= dec_ok ? d_imm : '0;
         out_wd          <= dec_ok & d_wd;
         out_rd          <= (dec_ok & d_wd) ? inst[11:7] : 5'd0;
         out_aluop       <= dec_ok ? d_aluop : ALU_NONE;
         out_alusel      <= dec_ok ? d_alusel : SEL_NONE;
         out_branch_type <= dec_ok ? d_br : BR_NONE;
         out_store_type  <= dec_ok ? d_st : ST_NONE;
         out_load_type   <= dec_ok ? d_ld : LD_NONE;
         out_jmp         <= dec_ok & d_jmp;
         out_jalr        <= dec_ok & d_jalr;
         out_csr_flag    <= dec_ok ? d_csr : CSR_NONE;
         out_sys         <= dec_ok ? d_sys : SYS_NONE;
      end else if (out_ready) begin
         out_valid <= 1'b0;
         out_pc    <= PC_RESET;
      end
   end
endmodule

// File: tb/tb_ysyx_22041211_idu_stage.sv
// tb/tb_ysyx_22041211_idu_stage.sv - table-driven scoreboard bench for the decode stage
module tb_ysyx_22041211_idu_stage;
   localparam logic [31:0] PC_RESET = 32'h8000_0000;
   localparam logic [3:0] A_NONE = 4'd0, A_ADD = 4'd1, A_SUB = 4'd2, A_SLTU = 4'd5, A_SRA = 4'd8;
   localparam logic [3:0] S_NONE = 4'b0000, S_R1 = 4'b0100, S_RR = 4'b0101, S_RI = 4'b0110,
                          S_PI = 4'b1010, S_P4 = 4'b1011, S_ZI = 4'b1110;

   logic        clock = 1'b0, reset = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [31:0] in_pc = '0, in_inst = '0;
   logic        in_ready, out_valid, out_wd, out_jmp, out_jalr, out_illegal;
   logic [31:0] out_pc, out_imm;
   logic [4:0]  out_rs1, out_rs2, out_rd;
   logic [3:0]  out_aluop, out_alusel;
   logic [2:0]  out_branch_type, out_load_type;
   logic [1:0]  out_store_type, out_csr_flag, out_sys;
   logic [11:0] out_csr_addr;

   ysyx_22041211_idu_stage dut (
      .clock(clock), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
      .in_pc(in_pc), .in_inst(in_inst), .out_valid(out_valid), .out_ready(out_ready),
      .out_pc(out_pc), .out_imm(out_imm), .out_rs1(out_rs1), .out_rs2(out_rs2),
      .out_rd(out_rd), .out_wd(out_wd), .out_aluop(out_aluop), .out_alusel(out_alusel),
      .out_branch_type(out_branch_type), .out_store_type(out_store_type),
      .out_load_type(out_load_type), .out_jmp(out_jmp), .out_jalr(out_jalr),
      .out_csr_flag(out_csr_flag), .out_csr_addr(out_csr_addr), .out_sys(out_sys),
      .out_illegal(out_illegal)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [31:0] pc;  logic [31:0] imm; logic [4:0] rs1; logic [4:0] rs2; logic [4:0] rd;
      logic wd; logic [3:0] aluop; logic [3:0] alusel; logic [2:0] br; logic [1:0] st;
      logic [2:0] ld; logic jmp; logic jalr; logic [1:0] csr; logic [11:0] csr_addr;
      logic [1:0] sys; logic ill;
   } bundle_t;

   typedef struct packed {
      logic [31:0] inst; logic [31:0] imm; logic wd; logic [4:0] rd; logic [3:0] aluop;
      logic [3:0] alusel; logic [2:0] br; logic [1:0] st; logic [2:0] ld; logic jmp;
      logic jalr; logic [1:0] csr; logic [1:0] sys; logic ill;
   } vec_t;

   int total = 0, bad = 0;
   bundle_t sb[$];
   vec_t tbl[22];

   function automatic vec_t mk(logic [31:0] inst, logic [31:0] imm, logic wd, logic [4:0] rd,
                               logic [3:0] aluop, logic [3:0] alusel, logic [2:0] br,
                               logic [1:0] st, logic [2:0] ld, logic jmp, logic jalr,
                               logic [1:0] csr, logic [1:0] sys, logic ill);
      vec_t v;
      v.inst = inst; v.imm = imm; v.wd = wd; v.rd = rd; v.aluop = aluop; v.alusel = alusel;
      v.br = br; v.st = st; v.ld = ld; v.jmp = jmp; v.jalr = jalr; v.csr = csr;
      v.sys = sys; v.ill = ill;
      return v;
   endfunction

   function automatic vec_t mk_ill(logic [31:0] inst);
      return mk(inst, 0, 0, 0, A_NONE, S_NONE, 0, 0, 0, 0, 0, 0, 0, 1);
   endfunction

   function automatic bundle_t expect_b(logic [31:0] pc, vec_t v);
      bundle_t b;
      b.pc = pc; b.imm = v.imm; b.rs1 = v.inst[19:15]; b.rs2 = v.inst[24:20]; b.rd = v.rd;
      b.wd = v.wd; b.aluop = v.aluop; b.alusel = v.alusel; b.br = v.br; b.st = v.st;
      b.ld = v.ld; b.jmp = v.jmp; b.jalr = v.jalr; b.csr = v.csr;
      b.csr_addr = v.inst[31:20]; b.sys = v.sys; b.ill = v.ill;
      return b;
   endfunction

   function automatic bundle_t got_now();
      bundle_t b;
      b.pc = out_pc; b.imm = out_imm; b.rs1 = out_rs1; b.rs2 = out_rs2; b.rd = out_rd;
      b.wd = out_wd; b.aluop = out_aluop; b.alusel = out_alusel; b.br = out_branch_type;
      b.st = out_store_type; b.ld = out_load_type; b.jmp = out_jmp; b.jalr = out_jalr;
      b.csr = out_csr_flag; b.csr_addr = out_csr_addr; b.sys = out_sys; b.ill = out_illegal;
      return b;
   endfunction

   task automatic check1(input string name, input logic [127:0] act, input logic [127:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, req);
      end
   endtask

   always @(negedge clock) begin
      if (!reset && !flush && out_valid && out_ready) begin
         if (sb.size() == 0) begin
            total++; bad++;
            $display("FAIL unexpected_output: got pc %h inst-bundle %h want nothing", out_pc, got_now());
         end else begin
            check1("bundle", got_now(), sb.pop_front());
         end
      end
   end

   task automatic step();
      @(posedge clock); #1;
   endtask

   task automatic send(input logic [31:0] pc, input vec_t v);
      int guard = 0;
      in_valid = 1'b1; in_pc = pc; in_inst = v.inst;
      while (!in_ready && guard < 100) begin step(); guard++; end
      if (guard >= 100) check1("in_ready_timeout", 0, 1);
      else sb.push_back(expect_b(pc, v));
      step();
      in_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int guard = 0;
      while (sb.size() != 0 && guard < 200) begin step(); guard++; end
      if (sb.size() != 0) begin
         check1("drain_timeout", 128'(sb.size()), 0);
         sb.delete();
      end
   endtask

   bundle_t reset_b;
   vec_t    v_addi;

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      longint t0, t1;
      reset_b = '0; reset_b.pc = PC_RESET;
      v_addi = mk(32'h00500093, 32'd5, 1, 1, A_ADD, S_RI, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[0]  = mk(32'h402081B3, 0, 1, 3, A_SUB, S_RR, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[1]  = mk(32'h0020A223, 32'd4, 0, 0, A_ADD, S_RI, 0, 2'd3, 0, 0, 0, 0, 0, 0);
      tbl[2]  = mk(32'h300312F3, 0, 1, 5, A_NONE, S_R1, 0, 0, 0, 0, 0, 2'd1, 0, 0);
      tbl[3]  = mk(32'h00000073, 0, 0, 0, A_NONE, S_NONE, 0, 0, 0, 0, 0, 0, 2'd1, 0);
      tbl[4]  = mk(32'h00100073, 0, 0, 0, A_NONE, S_NONE, 0, 0, 0, 0, 0, 0, 2'd2, 0);
      tbl[5]  = mk(32'h30200073, 0, 0, 0, A_NONE, S_NONE, 0, 0, 0, 0, 0, 0, 2'd3, 0);
      tbl[6]  = mk_ill(32'hFFFFFFFF);
`ifdef YSYX_22041211_RV32E_EN
      tbl[7]  = mk_ill(32'h00208833);
`else
      tbl[7]  = mk(32'h00208833, 0, 1, 16, A_ADD, S_RR, 0, 0, 0, 0, 0, 0, 0, 0);
`endif
      tbl[8]  = mk(32'hFFC12383, 32'hFFFFFFFC, 1, 7, A_ADD, S_RI, 0, 0, 3'd3, 0, 0, 0, 0, 0);
      tbl[9]  = mk(32'hFE208CE3, 32'hFFFFFFF8, 0, 0, A_NONE, S_RR, 3'd1, 0, 0, 0, 0, 0, 0, 0);
      tbl[10] = mk(32'h010000EF, 32'd16, 1, 1, A_ADD, S_P4, 0, 0, 0, 1, 0, 0, 0, 0);
      tbl[11] = mk(32'h00008067, 0, 1, 0, A_ADD, S_P4, 0, 0, 0, 1, 1, 0, 0, 0);
      tbl[12] = mk(32'h123452B7, 32'h12345000, 1, 5, A_ADD, S_ZI, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[13] = mk(32'h00001317, 32'h00001000, 1, 6, A_ADD, S_PI, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[14] = mk(32'h40325213, 32'h00000403, 1, 4, A_SRA, S_RI, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[15] = mk_ill(32'h40321213);
      tbl[16] = mk_ill(32'h022081B3);
      tbl[17] = mk(32'h0011C483, 32'd1, 1, 9, A_ADD, S_RI, 0, 0, 3'd4, 0, 0, 0, 0, 0);
      tbl[18] = mk(32'h34102573, 0, 1, 10, A_NONE, S_R1, 0, 0, 0, 0, 0, 2'd2, 0, 0);
      tbl[19] = mk(32'h007332B3, 0, 1, 5, A_SLTU, S_RR, 0, 0, 0, 0, 0, 0, 0, 0);
      tbl[20] = mk(32'h0020F263, 32'd4, 0, 0, A_NONE, S_RR, 3'd6, 0, 0, 0, 0, 0, 0, 0);
      tbl[21] = mk_ill(32'h00200073);

      repeat (3) @(posedge clock);
      #1 reset = 1'b0;
      check1("reset_bundle", got_now(), reset_b);
      check1("reset_valid", out_valid, 0);
      check1("reset_in_ready", in_ready, 1);

      out_ready = 1'b1;
      in_valid = 1'b1; in_pc = 32'h8000_0000; in_inst = v_addi.inst;
      sb.push_back(expect_b(32'h8000_0000, v_addi));
      step();
      check1("lat_edge_n", out_valid, 0);
      in_valid = 1'b0;
      step();
      check1("lat_edge_n1", out_valid, 1);
      wait_drain();

      t0 = $time;
      foreach (tbl[i]) send(32'h8000_0100 + 32'(i) * 4, tbl[i]);
      t1 = $time;
      check1("throughput_cycles", 128'((t1 - t0) / 10), 128'(22));
      wait_drain();

      out_ready = 1'b0;
      for (int k = 0; k < 5; k++) send(32'h8000_0200 + 32'(k) * 4, tbl[k % 2]);
      check1("full_in_ready", in_ready, 0);
      check1("hold_bundle0", got_now(), sb[0]);
      in_valid = 1'b1; in_pc = 32'h8000_0300; in_inst = v_addi.inst;
      repeat (3) step();
      in_valid = 1'b0;
      check1("hold_bundle1", got_now(), sb[0]);
      check1("hold_valid", out_valid, 1);
      check1("hold_in_ready", in_ready, 0);
      out_ready = 1'b1;
      wait_drain();

      out_ready = 1'b0;
      for (int k = 0; k < 4; k++) send(32'h8000_0400 + 32'(k) * 4, tbl[19]);
      in_valid = 1'b1; in_pc = 32'h8000_0500; in_inst = tbl[0].inst; flush = 1'b1;
      step();
      flush = 1'b0; in_valid = 1'b0;
      sb.delete();
      check1("flush_valid", out_valid, 0);
      check1("flush_in_ready", in_ready, 1);
      check1("flush_pc", out_pc, PC_RESET);
      out_ready = 1'b1;
      repeat (5) step();
      check1("flush_stays_empty", out_valid, 0);
      send(32'h8000_0600, v_addi);
      wait_drain();

      out_ready = 1'b0;
      for (int k = 0; k < 3; k++) send(32'h8000_0700 + 32'(k) * 4, tbl[12]);
      reset = 1'b1;
      step();
      reset = 1'b0;
      sb.delete();
      check1("midreset_bundle", got_now(), reset_b);
      check1("midreset_in_ready", in_ready, 1);
      out_ready = 1'b1;
      repeat (4) step();
      check1("midreset_empty", out_valid, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/ysyx_22041211_idu_stage.md
Name: ysyx_22041211_idu_stage

Overview:
- Registered, handshaked instruction-decode stage for the multi-cycle/pipelined NPC.
- Sits between IFU and EXU. Buffers fetched {pc, inst} pairs in a DEPTH-entry queue, decodes the head entry, and presents a registered decode bundle under valid/ready.
- Adds over the combinational decoder:
  - illegal-instruction and system-instruction (ecall/ebreak/mret) detection
  - flush
  - backpressure

Parameters:
- DEPTH, 4, input queue entries; power of two, at least 2.
- PC_RESET, 32'h8000_0000, value driven on out_pc while out_valid=0.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  discard all buffered and output-stage instructions (redirect/trap)
- in_valid  in  1  IFU offers {in_pc, in_inst}
- in_ready  out  1  queue can accept; equals !full
- in_pc  in  32  fetch PC
- in_inst  in  32  fetched instruction
- out_valid  out  1  decode bundle valid
- out_ready  in  1  EXU accepts bundle
- out_pc  out  32  PC of decoded instruction
- out_imm  out  32  sign-extended immediate; I/S/B/U/J formats per opcode
- out_rs1  out  5  inst[19:15]
- out_rs2  out  5  inst[24:20]
- out_rd  out  5  inst[11:7]; 0 when out_wd=0
- out_wd  out  1  register write enable
- out_aluop  out  4  ALU operation, define-header encoding
- out_alusel  out  4  operand select, define-header encoding
- out_branch_type  out  3  branch kind
- out_store_type  out  2  store size
- out_load_type  out  3  load size/sign
- out_jmp  out  1  jal/jalr
- out_jalr  out  1  target = rs1+imm (EXU computes); else pc+imm
- out_csr_flag  out  2  csrrw/csrrs/invalid
- out_csr_addr  out  12  inst[31:20]
- out_sys  out  2  0 none, 1 ecall, 2 ebreak, 3 mret
- out_illegal  out  1  undecodable instruction

Behaviour:
- Queue:
  - Circular buffer with wptr/rptr of log2(DEPTH) bits that wrap naturally, plus a count of log2(DEPTH)+1 bits.
  - Push on in_valid&in_ready. Pop when the queue is non-empty and the output register is empty or is being drained (out_ready).
  - Push and pop in the same cycle: count unchanged.
  - Full: in_ready=0 and in_inst is ignored.
  - Empty: no pop.
- Output register:
  - Loaded with decode(head) on pop. Holds stable while out_valid & !out_ready.
  - out_valid clears on out_ready when no pop occurs.
- Latency:
  - Instruction accepted at edge N appears with out_valid=1 after edge N+1 when queue and output register are empty.
  - Sustained throughput is 1 instr/cycle with out_ready held high.
- Decode, all outputs registered:
  - Covers RV32I ALU R/I, shifts (imm[11:5] checked), loads, stores, branches, jal, jalr, lui, auipc, csrrw, csrrs, ecall (0x00000073), ebreak (0x00100073), mret (0x30200073).
  - Field encodings come from the team's define header.
- Illegal instruction (any unmatched encoding, including bad funct7 or shift imm[11:5]):
  - out_illegal=1, out_wd=0, out_jmp=0, all type fields invalid, out_sys=0, out_pc valid.
- System instructions: out_sys set, out_wd=0.
- Flush:
  - At the edge, rptr=wptr=count=0 and out_valid=0.
  - Flush overrides a simultaneous push or pop; the concurrent in_inst is dropped.
  - in_ready=1 the cycle after.
- Reset (synchronous):
  - Queue empty; out_valid=0; in_ready=1.
  - All out_* bundle fields 0, except out_pc=PC_RESET.
  - Reset mid-stream discards everything.
- Bundle fields must not change while out_valid=1 and out_ready=0.

Optional Feature:
- Macro: YSYX_22041211_RV32E_EN.
- Defined: any used register index with bit4 set (rd if written, rs1/rs2 if read by that format) forces out_illegal=1 with the same side effects as above.
- Undefined: full 32-register RV32I decode; the check is absent.

Test Plan:
- addi x1,x0,5 (0x00500093) at pc 0x80000000 with out_ready=1 -> out_valid one cycle after acceptance; out_wd=1, out_rd=1, out_imm=5, ADD, SEL2_IMM/SEL1_REG1.
- sub x3,x1,x2 (0x402081B3) then sw x2,4(x1) (0x0020A223) back-to-back -> SUB with rd=3; then out_wd=0, STORE_SW_32, out_imm=4, out_rs2=2.
- Hold out_ready=0 and push DEPTH+1 instrs -> in_ready=0 after DEPTH+1 accepted (DEPTH in queue, 1 in output); bundle stable; release -> all drain in order.
- csrrw x5,0x300,x6 (0x300312F3) -> CSRRW, csr_addr=0x300, rd=5; ecall (0x00000073) -> out_sys=1, out_wd=0.
- 0xFFFFFFFF -> out_illegal=1, out_wd=0; with the macro, add x16,x1,x2 (0x00208833) -> illegal; without it -> legal add.
- Flush asserted with in_valid=1 and 3 queued -> next cycle out_valid=0, count=0; the flush-cycle instruction never appears.
